i2c_slave_regfile: RTL and testbench

Synthesizable I2C slave holding a DEPTH-entry byte register file addressed through an auto-incrementing pointer. It is the bench partner and on-chip peer for `I2C_master`, and supports both write and read transfers so that master-side write traffic can be read back and checked. Pin conventions match the master: `_i` is the sampled input, `_t` is the drive enable, and `_o` is the drive value. A parallel side port gives user logic direct access to the register file.

---
 rtl/i2c_slave_regfile.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
// I2C slave in front of a DEPTH x 8 register file. The register file is
// addressed by a pointer that auto-increments and wraps modulo DEPTH.
// The slave never drives SCL. SDA is open-drain: sda_o is tied low and
// sda_t pulls the line low. A side port gives user logic direct access
// to the registers. When a bus write and a side-port write hit the same
// register in the same cycle, the bus write takes priority.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = $clog2(DEPTH),
  parameter int         FILTER     = 3
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  input  logic [PTR_W-1:0] usr_addr,
  output logic [7:0]       usr_rdata,
  input  logic             usr_we,
  input  logic [7:0]       usr_wdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_byte,
  output logic             busy
);

  localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    A_ACK,
    PTR,
    WR,
    RD,
    R_ACK,
    IGNORE
  } state_t;

  genvar gi;

  // ---------------------------------------------------------------
  // Input conditioning.
  // Index 0 is SCL and index 1 is SDA.
  // Each pin passes through a 2-flop synchroniser and then a
  // stability filter.
  // ---------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] line_filt;

  assign pin_raw = {sda_i, scl_i};

  for (gi = 0; gi < 2; gi++) begin : g_cond
    logic [1:0]       sync_reg;
    logic             filt_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronise the pin. The filtered level changes only after the
    // synchronised value has differed from it for FILTER consecutive
    // cycles.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sync_reg <= 2'b11;
        filt_reg <= 1'b1;
        cnt_reg  <= '0;
      end else begin
        sync_reg <= {sync_reg[0], pin_raw[gi]};
        if (sync_reg[1] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(FILTER - 1)) begin
          filt_reg <= sync_reg[1];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign line_filt[gi] = filt_reg;
  end

  logic scl_f;
  logic sda_f;
  logic scl_prev_reg;
  logic sda_prev_reg;

  assign scl_f = line_filt[0];
  assign sda_f = line_filt[1];

  // Hold the previous filtered levels so edges can be detected.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_prev_reg <= scl_f;
      sda_prev_reg <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_ev;
  logic stop_ev;

  assign scl_rise = scl_f & ~scl_prev_reg;
  assign scl_fall = ~scl_f & scl_prev_reg;
  assign start_ev = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_ev  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  // ---------------------------------------------------------------
  // Register file: one cell per entry.
  // ---------------------------------------------------------------
  logic [7:0]       regs [DEPTH];
  logic             wr_stb_reg;
  logic [PTR_W-1:0] wr_idx_reg;
  logic [7:0]       wr_byte_reg;

  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [7:0] cell_reg;

    // Bus writes are checked first, so they win a same-cycle collision
    // with the side port.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        cell_reg <= 8'h00;
      end else if (wr_stb_reg && (wr_idx_reg == PTR_W'(gi))) begin
        cell_reg <= wr_byte_reg;
      end else if (usr_we && (usr_addr == PTR_W'(gi))) begin
        cell_reg <= usr_wdata;
      end
    end

    assign regs[gi] = cell_reg;
  end

  // ---------------------------------------------------------------
  // Protocol FSM.
  // ---------------------------------------------------------------
  state_t           state_reg;
  logic [7:0]       shift_reg;
  logic [3:0]       bit_cnt_reg;
  logic             rw_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic             sda_t_reg;
  logic             ack_pend_reg;   // ACK to be driven at the next SCL fall
  logic             ack_slot_reg;   // currently driving the ACK of a received byte
  logic             byte_done_reg;  // one cycle after the 8th sampled bit
  logic             busy_reg;

  logic [7:0]       ptr_data;
  logic [PTR_W-1:0] ptr_inc;
  logic             addr_match;
  logic             ptr_in_range;

  assign ptr_data     = regs[ptr_reg];
  assign ptr_inc      = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  assign addr_match   = (shift_reg[7:1] == SLAVE_ADDR);
  assign ptr_in_range = ({1'b0, shift_reg} < 9'(DEPTH));

  // Single FSM. Bits are sampled on the SCL rise. sda_t is only changed
  // on the SCL fall. START and STOP override every state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'h00;
      bit_cnt_reg   <= 4'd0;
      rw_reg        <= 1'b0;
      ptr_reg       <= '0;
      sda_t_reg     <= 1'b0;
      ack_pend_reg  <= 1'b0;
      ack_slot_reg  <= 1'b0;
      byte_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      wr_stb_reg    <= 1'b0;
      wr_idx_reg    <= '0;
      wr_byte_reg   <= 8'h00;
    end else begin
      wr_stb_reg    <= 1'b0;
      byte_done_reg <= 1'b0;
      if (stop_ev) begin
        state_reg    <= IDLE;
        sda_t_reg    <= 1'b0;
        ack_pend_reg <= 1'b0;
        ack_slot_reg <= 1'b0;
        busy_reg     <= 1'b0;
      end else if (start_ev) begin
        // A repeated START keeps the pointer.
        state_reg    <= ADDR;
        sda_t_reg    <= 1'b0;
        ack_pend_reg <= 1'b0;
        ack_slot_reg <= 1'b0;
        bit_cnt_reg  <= 4'd0;
      end else begin
        case (state_reg)
          IDLE, IGNORE: begin
            sda_t_reg <= 1'b0;
          end

          ADDR, PTR, WR: begin
            // Shift in data bits. The ACK clock of a byte is not shifted.
            if (scl_rise && !ack_slot_reg) begin
              shift_reg   <= {shift_reg[6:0], sda_f};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                byte_done_reg <= 1'b1;
              end
            end
            // Drive the ACK on the fall after the 8th bit, and release it
            // on the fall after the ACK clock.
            if (scl_fall) begin
              if (ack_pend_reg) begin
                sda_t_reg    <= 1'b1;
                ack_pend_reg <= 1'b0;
                ack_slot_reg <= 1'b1;
              end else if (ack_slot_reg) begin
                sda_t_reg    <= 1'b0;
                ack_slot_reg <= 1'b0;
                bit_cnt_reg  <= 4'd0;
              end
            end
            if (byte_done_reg) begin
              if (state_reg == ADDR) begin
                if (addr_match) begin
                  state_reg    <= A_ACK;
                  rw_reg       <= shift_reg[0];
                  ack_pend_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                end else begin
                  state_reg <= IGNORE;
                end
              end else if (state_reg == PTR) begin
                if (ptr_in_range) begin
                  ptr_reg      <= shift_reg[PTR_W-1:0];
                  ack_pend_reg <= 1'b1;
                  state_reg    <= WR;
                end else begin
                  state_reg <= IGNORE;
                end
              end else begin
                wr_stb_reg   <= 1'b1;
                wr_idx_reg   <= ptr_reg;
                wr_byte_reg  <= shift_reg;
                ptr_reg      <= ptr_inc;
                ack_pend_reg <= 1'b1;
              end
            end
          end

          A_ACK: begin
            if (scl_fall) begin
              if (ack_pend_reg) begin
                sda_t_reg    <= 1'b1;
                ack_pend_reg <= 1'b0;
              end else if (rw_reg) begin
                // The byte is latched here. Later side-port writes do not
                // affect the byte that is being shifted out.
                state_reg   <= RD;
                shift_reg   <= ptr_data;
                sda_t_reg   <= ~ptr_data[7];
                bit_cnt_reg <= 4'd1;
              end else begin
                state_reg   <= PTR;
                sda_t_reg   <= 1'b0;
                bit_cnt_reg <= 4'd0;
              end
            end
          end

          RD: begin
            // bit_cnt_reg counts the bits already presented on the line.
            if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_t_reg <= 1'b0;
                ptr_reg   <= ptr_inc;
                state_reg <= R_ACK;
              end else begin
                shift_reg   <= {shift_reg[6:0], 1'b0};
                sda_t_reg   <= ~shift_reg[6];
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

          R_ACK: begin
            if (scl_rise && sda_f) begin
              state_reg <= IGNORE;
            end else if (scl_fall) begin
              state_reg   <= RD;
              shift_reg   <= ptr_data;
              sda_t_reg   <= ~ptr_data[7];
              bit_cnt_reg <= 4'd1;
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_reg;
  assign usr_rdata = regs[usr_addr];
  assign wr_stb    = wr_stb_reg;
  assign wr_idx    = wr_idx_reg;
  assign wr_byte   = wr_byte_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile
// Directed bench for i2c_slave_regfile (SLAVE_ADDR=0x50, DEPTH=16,
// FILTER=3). The bench acts as the I2C master through an open-drain SDA
// model. It prints one line per bus byte transaction.
module tb_i2c_slave_regfile;

  localparam int Q = 100;  // quarter SCL period; the clock period is 10

  logic       clock;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_o;
  logic       sda_t;
  logic [3:0] usr_addr;
  logic [7:0] usr_rdata;
  logic       usr_we;
  logic [7:0] usr_wdata;
  logic       wr_stb;
  logic [3:0] wr_idx;
  logic [7:0] wr_byte;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         stb_cnt = 0;
  logic [3:0] stb_idx[$];
  logic [7:0] stb_dat[$];
  logic       sdat_seen = 1'b0;
  logic       busy_seen = 1'b0;

  // Open-drain SDA: the line is low if either side pulls it low.
  assign sda_line = sda_m & ~sda_t;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h50),
    .DEPTH      (16),
    .FILTER     (3)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .usr_addr  (usr_addr),
    .usr_rdata (usr_rdata),
    .usr_we    (usr_we),
    .usr_wdata (usr_wdata),
    .wr_stb    (wr_stb),
    .wr_idx    (wr_idx),
    .wr_byte   (wr_byte),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Record bus-write strobes and whether sda_t or busy were ever high.
  always @(negedge clock) begin
    if (wr_stb) begin
      stb_cnt++;
      stb_idx.push_back(wr_idx);
      stb_dat.push_back(wr_byte);
    end
    if (sda_t) sdat_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;
    #Q scl = 1'b1;
    #Q s = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  // Same as bus_bit, with a 2-clock low glitch on SDA while SCL is high.
  task automatic bus_bit_glitch(input logic b, output logic s);
    sda_m = b;
    #Q scl = 1'b1;
    #30 sda_m = 1'b0;
    #20 sda_m = b;
    #50 s = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start;
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
    #Q;
  endtask

  task automatic bus_write(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
    $display("bus write %02h ack=%0d", b, ack);
  endtask

  task automatic bus_write_glitch(input logic [7:0] b, output logic ack);
    logic s;
    bus_bit_glitch(b[7], s);
    for (int i = 6; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
    $display("bus write (glitched) %02h ack=%0d", b, ack);
  endtask

  task automatic bus_read(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~mack, s);
    $display("bus read %02h master_ack=%0d", d, mack);
  endtask

  task automatic usr_write(input logic [3:0] a, input logic [7:0] d);
    usr_addr  = a;
    usr_wdata = d;
    usr_we    = 1'b1;
    @(posedge clock);
    #2 usr_we = 1'b0;
    $display("side write reg[%0d]=%02h", a, d);
  endtask

  task automatic usr_peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    usr_addr = a;
    #1;
    check_eq(tag, {24'h0, usr_rdata}, {24'h0, exp});
    #9;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;
    logic       found;

    rst_n     = 1'b0;
    scl       = 1'b1;
    sda_m     = 1'b1;
    usr_we    = 1'b0;
    usr_addr  = 4'd0;
    usr_wdata = 8'h00;
    repeat (3) @(posedge clock);
    #2 rst_n = 1'b1;

    // Reset state
    check_eq("rst_sda_t", {31'h0, sda_t}, 32'h0);
    check_eq("rst_sda_o", {31'h0, sda_o}, 32'h0);
    check_eq("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    usr_peek("rst_reg7", 4'd7, 8'h00);

    // The pointer readback in test 2 uses this value.
    usr_write(4'd1, 8'hC3);
    usr_peek("side_reg1", 4'd1, 8'hC3);

    // 1: write with auto-increment and wrap
    base = stb_cnt;
    stb_idx.delete();
    stb_dat.delete();
    bus_start;
    bus_write(8'hA0, ack); check_eq("t1_addr_ack", {31'h0, ack}, 32'h1);
    bus_write(8'h0E, ack); check_eq("t1_ptr_ack", {31'h0, ack}, 32'h1);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    bus_write(8'h11, ack); check_eq("t1_d0_ack", {31'h0, ack}, 32'h1);
    bus_write(8'h22, ack); check_eq("t1_d1_ack", {31'h0, ack}, 32'h1);
    bus_write(8'h33, ack); check_eq("t1_d2_ack", {31'h0, ack}, 32'h1);
    bus_stop;
    check_eq("t1_busy_after_stop", {31'h0, busy}, 32'h0);
    check_eq("t1_stb_count", stb_cnt - base, 32'd3);
    check_eq("t1_idx0", {28'h0, stb_idx[0]}, 32'd14);
    check_eq("t1_idx1", {28'h0, stb_idx[1]}, 32'd15);
    check_eq("t1_idx2", {28'h0, stb_idx[2]}, 32'd0);
    check_eq("t1_dat0", {24'h0, stb_dat[0]}, 32'h11);
    check_eq("t1_dat2", {24'h0, stb_dat[2]}, 32'h33);
    usr_peek("t1_reg14", 4'd14, 8'h11);
    usr_peek("t1_reg15", 4'd15, 8'h22);
    usr_peek("t1_reg0", 4'd0, 8'h33);

    // 2: set the pointer, repeated START, then read
    bus_start;
    bus_write(8'hA0, ack); check_eq("t2_addr_ack", {31'h0, ack}, 32'h1);
    bus_write(8'h0E, ack); check_eq("t2_ptr_ack", {31'h0, ack}, 32'h1);
    bus_start;
    bus_write(8'hA1, ack); check_eq("t2_raddr_ack", {31'h0, ack}, 32'h1);
    bus_read(1'b1, d); check_eq("t2_rd0", {24'h0, d}, 32'h11);
    bus_read(1'b1, d); check_eq("t2_rd1", {24'h0, d}, 32'h22);
    bus_read(1'b0, d); check_eq("t2_rd2", {24'h0, d}, 32'h33);
    check_eq("t2_sda_released", {31'h0, sda_t}, 32'h0);
    bus_stop;
    // The pointer is now 1. Reading without a pointer write returns reg[1].
    bus_start;
    bus_write(8'hA1, ack); check_eq("t2_raddr2_ack", {31'h0, ack}, 32'h1);
    bus_read(1'b0, d); check_eq("t2_ptr_is_1", {24'h0, d}, 32'hC3);
    bus_stop;

    // 3: address mismatch
    base = stb_cnt;
    sdat_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start;
    bus_write(8'hA2, ack); check_eq("t3_addr_nack", {31'h0, ack}, 32'h0);
    bus_write(8'h55, ack); check_eq("t3_data_nack", {31'h0, ack}, 32'h0);
    bus_stop;
    check_eq("t3_sda_t_never", {31'h0, sdat_seen}, 32'h0);
    check_eq("t3_busy_never", {31'h0, busy_seen}, 32'h0);
    check_eq("t3_no_stb", stb_cnt - base, 32'd0);

    // 4: out-of-range pointer
    base = stb_cnt;
    bus_start;
    bus_write(8'hA0, ack); check_eq("t4_addr_ack", {31'h0, ack}, 32'h1);
    bus_write(8'h10, ack); check_eq("t4_ptr_nack", {31'h0, ack}, 32'h0);
    bus_write(8'h99, ack); check_eq("t4_data_nack", {31'h0, ack}, 32'h0);
    bus_stop;
    check_eq("t4_no_stb", stb_cnt - base, 32'd0);
    usr_peek("t4_reg0", 4'd0, 8'h33);
    usr_peek("t4_reg14", 4'd14, 8'h11);

    // 5a: side-port write collides with a bus write to index 3
    found = 1'b0;
    fork
      begin
        logic a1;
        logic a2;
        logic a3;
        bus_start;
        bus_write(8'hA0, a1);
        bus_write(8'h03, a2);
        bus_write(8'h01, a3);
        bus_stop;
        check_eq("t5_acks", {29'h0, a1, a2, a3}, 32'h7);
      end
      begin
        for (int i = 0; i < 3000 && !found; i++) begin
          @(negedge clock);
          if (wr_stb) found = 1'b1;
        end
        if (found) begin
          usr_addr  = 4'd3;
          usr_wdata = 8'h7E;
          usr_we    = 1'b1;
          @(posedge clock);
          #2 usr_we = 1'b0;
        end
      end
    join
    check_eq("t5_stb_seen", {31'h0, found}, 32'h1);
    usr_peek("t5_bus_wins", 4'd3, 8'h01);

    // 5b: side-port write, then read it back over the bus
    usr_write(4'd4, 8'h7E);
    bus_start;
    bus_write(8'hA0, ack);
    bus_write(8'h04, ack);
    bus_start;
    bus_write(8'hA1, ack); check_eq("t5_raddr_ack", {31'h0, ack}, 32'h1);
    bus_read(1'b0, d); check_eq("t5_readback", {24'h0, d}, 32'h7E);
    bus_stop;

    // 6a: a 2-clock SDA glitch while SCL is high must not abort the write
    bus_start;
    bus_write(8'hA0, ack);
    bus_write(8'h05, ack);
    bus_write_glitch(8'h80, ack); check_eq("t6_glitch_ack", {31'h0, ack}, 32'h1);
    bus_stop;
    usr_peek("t6_glitch_reg5", 4'd5, 8'h80);

    // 6b: reset in the middle of a read byte (reg[14]=0x11, so it starts with 0s)
    bus_start;
    bus_write(8'hA0, ack);
    bus_write(8'h0E, ack);
    bus_start;
    bus_write(8'hA1, ack);
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q check_eq("t6_driving_before_rst", {31'h0, sda_t}, 32'h1);
    rst_n = 1'b0;
    #1 check_eq("t6_async_release", {31'h0, sda_t}, 32'h0);
    #(Q - 1) scl = 1'b0;
    #Q rst_n = 1'b1;
    #Q;
    sdat_seen = 1'b0;
    for (int i = 0; i < 8; i++) bus_bit(1'b1, ack);
    check_eq("t6_silent_after_rst", {31'h0, sdat_seen}, 32'h0);
    check_eq("t6_busy_after_rst", {31'h0, busy}, 32'h0);
    usr_peek("t6_regs_cleared", 4'd14, 8'h00);
    bus_stop;
    bus_start;
    bus_write(8'hA0, ack); check_eq("t6_resume_ack", {31'h0, ack}, 32'h1);
    bus_stop;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
